// File: rtl/prsc_sched_pkg.sv
// prsc_sched_pkg: shared types, default sizes and helpers for the shared
// prescaler scheduler (prsc_sched) and its round-robin arbiter.
package prsc_sched_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DIV_W   = 4;
  localparam int DEF_BURST_W = 8;
  // Widest divide field eff_div can handle.
  localparam int MAX_DIV_W   = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  // A divide ratio of zero behaves like one (tick every cycle).
  function automatic logic [MAX_DIV_W-1:0] eff_div(input logic [MAX_DIV_W-1:0] d);
    return (d == '0) ? MAX_DIV_W'(1) : d;
  endfunction

endpackage

// File: rtl/prsc_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Searches upward from ptr with
// wrap and returns the first active requester as one-hot plus its index.
// Caller is responsible for only using the result when req is nonzero.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);

  logic [IW:0]   sum;
  logic [IW-1:0] j;
  logic          found;

  // Walk candidates ptr, ptr+1, ... (mod NUM_REQ); first active one wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    j     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
      j = sum[IW-1:0];
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/prsc_sched.sv
// prsc_sched: one shared tick prescaler time-multiplexed between NUM_REQ
// timer requesters. IDLE arbitrates round-robin and latches the winner's
// divide/burst, LOAD presents the grant, RUN emits burst ticks spaced by the
// effective divide ratio, then the grant is released for one IDLE cycle.
// Optional build macro PRSC_SCHED_ABORT_EN: adds abort_o and cancels a burst
// when the granted requester drops its request during RUN.
module prsc_sched
  import prsc_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DIV_W   = DEF_DIV_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       en_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*DIV_W-1:0]   div_i,
  input  logic [NUM_REQ*BURST_W-1:0] burst_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic                       tick_o,
  output logic [NUM_REQ-1:0]         done_o,
  output logic                       busy_o
`ifdef PRSC_SCHED_ABORT_EN
  ,
  output logic                       abort_o
`endif
);

  localparam int IW = $clog2(NUM_REQ);

  state_e                          state;
  logic   [IW-1:0]                 ptr;
  logic   [IW-1:0]                 ptr_nxt;
  logic   [NUM_REQ-1:0]            arb_gnt;
  logic   [IW-1:0]                 arb_idx;
  logic   [NUM_REQ-1:0][DIV_W-1:0]   div_arr;
  logic   [NUM_REQ-1:0][BURST_W-1:0] burst_arr;
  logic   [DIV_W-1:0]              div_lat;   // already max(div,1)
  logic   [DIV_W-1:0]              div_cnt;
  logic   [DIV_W-1:0]              cnt_nxt;
  logic   [BURST_W-1:0]            tick_cnt;
  logic                            hit;
  logic                            last;
  logic                            abort_hit;

  assign div_arr   = div_i;
  assign burst_arr = burst_i;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req (req_i),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Next pointer is one past the winner, wrapping at NUM_REQ.
  assign ptr_nxt = (arb_idx == IW'(NUM_REQ-1)) ? '0 : arb_idx + IW'(1);

  // Divider step: the cycle that reaches the effective ratio produces a tick.
  assign cnt_nxt = div_cnt + DIV_W'(1);
  assign hit     = (cnt_nxt == div_lat);
  assign last    = (tick_cnt == BURST_W'(1));

`ifdef PRSC_SCHED_ABORT_EN
  // Granted requester let go of its request while the burst is running.
  assign abort_hit = (state == S_RUN) && ((gnt_o & req_i) == '0);
`else
  assign abort_hit = 1'b0;
`endif

  // Scheduler FSM with registered outputs; en_i low freezes everything but
  // still lets one-cycle pulses fall.
  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      state    <= S_IDLE;
      ptr      <= '0;
      div_lat  <= '0;
      div_cnt  <= '0;
      tick_cnt <= '0;
      gnt_o    <= '0;
      tick_o   <= 1'b0;
      done_o   <= '0;
      busy_o   <= 1'b0;
`ifdef PRSC_SCHED_ABORT_EN
      abort_o  <= 1'b0;
`endif
    end else begin
      tick_o <= 1'b0;
      done_o <= '0;
`ifdef PRSC_SCHED_ABORT_EN
      abort_o <= 1'b0;
`endif
      if (en_i) begin
        case (state)
          S_IDLE: begin
            if (gnt_o != '0) begin
              // Release cycle after done/abort: drop grant, no arbitration.
              gnt_o  <= '0;
              busy_o <= 1'b0;
            end else if (req_i != '0) begin
              gnt_o    <= arb_gnt;
              busy_o   <= 1'b1;
              ptr      <= ptr_nxt;
              div_lat  <= DIV_W'(eff_div(MAX_DIV_W'(div_arr[arb_idx])));
              tick_cnt <= burst_arr[arb_idx];
              div_cnt  <= '0;
              // Empty burst completes inside LOAD.
              if (burst_arr[arb_idx] == '0) done_o <= arb_gnt;
              state    <= S_LOAD;
            end
          end
          S_LOAD, S_RUN: begin
            if (state == S_LOAD && tick_cnt == '0) begin
              gnt_o  <= '0;
              busy_o <= 1'b0;
              state  <= S_IDLE;
            end else if (abort_hit) begin
`ifdef PRSC_SCHED_ABORT_EN
              abort_o <= 1'b1;
`endif
              state <= S_IDLE;
            end else if (hit) begin
              tick_o   <= 1'b1;
              div_cnt  <= '0;
              tick_cnt <= tick_cnt - BURST_W'(1);
              if (last) begin
                done_o <= gnt_o;
                state  <= S_IDLE;
              end else begin
                state  <= S_RUN;
              end
            end else begin
              div_cnt <= cnt_nxt;
              state   <= S_RUN;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prsc_sched.sv
// tb_prsc_sched: directed stimulus for prsc_sched. Each scenario pushes the
// cycle-exact events it expects (grant edges, ticks, done/abort pulses) into
// a queue; a monitor pops and compares whenever the DUT shows an event.
module tb_prsc_sched;
  localparam int NUM_REQ = 4;
  localparam int DIV_W   = 4;
  localparam int BURST_W = 8;

  logic                       clk_i = 1'b0;
  logic                       rstn_i = 1'b1;
  logic                       en_i = 1'b1;
  logic [NUM_REQ-1:0]         req_i = '0;
  logic [NUM_REQ*DIV_W-1:0]   div_i = '0;
  logic [NUM_REQ*BURST_W-1:0] burst_i = '0;
  logic [NUM_REQ-1:0]         gnt_o;
  logic                       tick_o;
  logic [NUM_REQ-1:0]         done_o;
  logic                       busy_o;
`ifdef PRSC_SCHED_ABORT_EN
  logic                       abort_o;
`endif

  prsc_sched #(.NUM_REQ(NUM_REQ), .DIV_W(DIV_W), .BURST_W(BURST_W)) dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .en_i    (en_i),
    .req_i   (req_i),
    .div_i   (div_i),
    .burst_i (burst_i),
    .gnt_o   (gnt_o),
    .tick_o  (tick_o),
    .done_o  (done_o),
    .busy_o  (busy_o)
`ifdef PRSC_SCHED_ABORT_EN
    ,
    .abort_o (abort_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int                 cyc;
    bit                 tick;
    logic [NUM_REQ-1:0] done;
    bit                 abrt;
    logic [NUM_REQ-1:0] gnt;
  } ev_t;

  ev_t q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  logic [NUM_REQ-1:0] prev_gnt = '0;

  // Monitor: any pulse or grant change is an event to be matched in order.
  always @(negedge clk_i) begin
    ev_t  e;
    logic ab;
    ab = 1'b0;
`ifdef PRSC_SCHED_ABORT_EN
    ab = abort_o;
`endif
    if (tick_o || done_o != '0 || ab || gnt_o != prev_gnt) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: cyc=%0d tick=%0b done=%b abort=%0b gnt=%b busy=%0b, no event expected",
                 cyc, tick_o, done_o, ab, gnt_o, busy_o);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.tick != tick_o || e.done != done_o || e.abrt != ab ||
            e.gnt != gnt_o || busy_o != (e.gnt != '0)) begin
          n_err++;
          $display("FAIL event: got cyc=%0d tick=%0b done=%b abort=%0b gnt=%b busy=%0b; need cyc=%0d tick=%0b done=%b abort=%0b gnt=%b busy=%0b",
                   cyc, tick_o, done_o, ab, gnt_o, busy_o,
                   e.cyc, e.tick, e.done, e.abrt, e.gnt, (e.gnt != '0));
        end
      end
    end
    prev_gnt = gnt_o;
  end

  task automatic push(input int c, input bit t, input logic [NUM_REQ-1:0] d,
                      input bit a, input logic [NUM_REQ-1:0] g);
    ev_t e;
    e.cyc = c; e.tick = t; e.done = d; e.abrt = a; e.gnt = g;
    q.push_back(e);
  endtask

  // Expected events of one burst whose request is first seen in cycle c0.
  // pt >= 0: a pause of plen cycles delays every tick after tick pt.
  task automatic exp_burst(input int c0, input int k, input int dv, input int bu,
                           input int pt, input int plen, output int fall);
    int eff, l, t;
    logic [NUM_REQ-1:0] oh;
    eff = (dv == 0) ? 1 : dv;
    l   = c0 + 1;
    oh  = '0;
    oh[k] = 1'b1;
    if (bu == 0) begin
      push(l, 1'b0, oh, 1'b0, oh);
      fall = l + 1;
    end else begin
      push(l, 1'b0, '0, 1'b0, oh);
      t = l;
      for (int i = 1; i <= bu; i++) begin
        t += eff;
        if (i == pt + 1) t += plen;
        push(t, 1'b1, (i == bu) ? oh : '0, 1'b0, oh);
      end
      fall = t + 1;
    end
    push(fall, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h need %0h", name, got, exp);
    end
  endtask

  task automatic set_cfg(input int k, input int dv, input int bu);
    div_i[k*DIV_W +: DIV_W]       = DIV_W'(dv);
    burst_i[k*BURST_W +: BURST_W] = BURST_W'(bu);
  endtask

  // One requester alone; request dropped once it can no longer be re-granted.
  task automatic run_one(input int k, input int dv, input int bu, input bit pause);
    int c0, fall, l;
    set_cfg(k, dv, bu);
    c0 = cyc;
    req_i[k] = 1'b1;
    exp_burst(c0, k, dv, bu, pause ? 1 : -1, 5, fall);
    l = c0 + 1;
    if (pause) begin
      tick_to(l + 3);
      en_i = 1'b0;
      tick_to(l + 8);
      en_i = 1'b1;
    end
    tick_to((bu == 0) ? l : fall - 1);
    req_i[k] = 1'b0;
    tick_to(fall + 1);
  endtask

  initial begin
    int c0, fall, l;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("reset_gnt",  32'(gnt_o),  32'h0);
    chk("reset_tick", 32'(tick_o), 32'h0);
    chk("reset_done", 32'(done_o), 32'h0);
    chk("reset_busy", 32'(busy_o), 32'h0);
    rstn_i = 1'b0;
    tick_to(cyc + 2);

    // Single requester: ticks 3 apart, done with the 4th.
    run_one(0, 3, 4, 1'b0);
    // Empty burst: done in LOAD, no tick.
    run_one(1, 0, 0, 1'b0);
    // div 0 acts as 1: three back-to-back ticks.
    run_one(2, 0, 3, 1'b0);
    // Pause of 5 cycles after the first tick.
    run_one(3, 2, 3, 1'b1);

    // Round-robin with everybody requesting: 0,1,2,3,0.
    for (int k = 0; k < NUM_REQ; k++) set_cfg(k, 1, 2);
    c0 = cyc;
    req_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_burst(c0, g % NUM_REQ, 1, 2, -1, 0, fall);
      if (g < 4) c0 = fall;
    end
    tick_to(fall - 1);
    req_i = '0;
    tick_to(fall + 1);

    // Requester 1 drops its request after its first tick; 2 is waiting.
    set_cfg(1, 2, 4);
    set_cfg(2, 1, 1);
    c0 = cyc;
    req_i = 4'b0110;
`ifdef PRSC_SCHED_ABORT_EN
    push(c0 + 1, 1'b0, '0, 1'b0, 4'b0010);
    push(c0 + 3, 1'b1, '0, 1'b0, 4'b0010);
    push(c0 + 4, 1'b0, '0, 1'b1, 4'b0010);
    push(c0 + 5, 1'b0, '0, 1'b0, 4'b0000);
    fall = c0 + 5;
`else
    exp_burst(c0, 1, 2, 4, -1, 0, fall);
`endif
    tick_to(c0 + 3);
    req_i[1] = 1'b0;
    c0 = fall;
    exp_burst(c0, 2, 1, 1, -1, 0, fall);
    tick_to(fall - 1);
    req_i[2] = 1'b0;
    tick_to(fall + 1);

    // Longest burst at the slowest ratio.
    run_one(3, 15, 255, 1'b0);

    // Reset after the 2nd tick of requester 2 (div 3, burst 5).
    set_cfg(2, 3, 5);
    c0 = cyc;
    req_i[2] = 1'b1;
    l = c0 + 1;
    push(l,     1'b0, '0, 1'b0, 4'b0100);
    push(l + 3, 1'b1, '0, 1'b0, 4'b0100);
    push(l + 6, 1'b1, '0, 1'b0, 4'b0100);
    push(l + 7, 1'b0, '0, 1'b0, 4'b0000);
    tick_to(l + 7);
    rstn_i = 1'b1;
    req_i  = '0;
    #1;
    chk("midrst_gnt",  32'(gnt_o),  32'h0);
    chk("midrst_tick", 32'(tick_o), 32'h0);
    chk("midrst_done", 32'(done_o), 32'h0);
    chk("midrst_busy", 32'(busy_o), 32'h0);
    tick_to(l + 10);
    rstn_i = 1'b0;
    // Pointer is back at 0, so 0 beats 3.
    set_cfg(0, 1, 1);
    set_cfg(3, 1, 1);
    c0 = cyc;
    req_i = 4'b1001;
    exp_burst(c0, 0, 1, 1, -1, 0, fall);
    tick_to(fall - 1);
    req_i = '0;
    tick_to(fall + 3);

    chk("events_left", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prsc_sched.md
Name: prsc_sched

Overview:
- Shares one tick-generating prescaler counter between NUM_REQ requesters.
- Each requester asks for a divide ratio and a burst length (number of ticks).
- Round-robin arbitration picks one requester, loads its divider, emits its ticks, then releases.
- Sits between peripheral timers (UART baud, PWM, debounce) and the system clock-enable network.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DIV_W, 4, width of each divide-ratio field
- BURST_W, 8, width of each burst-length field

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  reset
- en_i  in  1  global enable; low freezes the block
- req_i  in  NUM_REQ  per-requester request level
- div_i  in  NUM_REQ*DIV_W  packed divide ratios, requester k at bits [k*DIV_W +: DIV_W]
- burst_i  in  NUM_REQ*BURST_W  packed burst lengths, same packing
- gnt_o  out  NUM_REQ  one-hot grant
- tick_o  out  1  one-cycle clock-enable pulse for the granted requester
- done_o  out  NUM_REQ  one-cycle pulse when the burst for requester k completes
- busy_o  out  1  high while in the LOAD or RUN state

Behaviour:
- Reset: rstn_i, asynchronous, active-high; clock clk_i.
- While rstn_i = 1: state IDLE; gnt_o, tick_o, done_o and busy_o are 0; counters are 0; round-robin pointer is 0, so requester 0 has first priority.
- States: IDLE, LOAD, RUN.
- IDLE:
  - If en_i = 1 and req_i is nonzero, choose the winner round-robin, starting at the pointer and searching upward with wrap.
  - Latch the winner's div and burst values; go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (1 cycle):
  - gnt_o goes one-hot and busy_o goes to 1.
  - Divider counter is cleared to 0 and tick counter is set to the latched burst.
  - Latched burst = 0: pulse done_o[k] and return to IDLE, with no ticks emitted.
  - Otherwise go to RUN.
- RUN:
  - Each cycle with en_i = 1, the divider counter increments.
  - When the counter equals the effective div, tick_o = 1 for that cycle, the counter returns to 0, and the tick counter decrements.
  - Effective div = max(latched div, 1), so div = 0 is treated as 1.
  - Tick period = effective div cycles. div = 1 gives a tick every cycle; div = 3 gives a tick every 3rd cycle.
  - The first tick comes effective-div cycles after LOAD.
  - On the last tick, done_o[k] pulses in the same cycle as tick_o, and the next state is IDLE.
- Common to all states:
  - gnt_o and busy_o drop in the cycle after done_o.
  - The pointer moves to the winner + 1 (mod NUM_REQ) when LOAD is entered.
- en_i = 0 in RUN: the divider counter and tick counter hold, tick_o is 0, gnt_o is held, and no timeout applies.
- en_i = 0 in IDLE: no arbitration takes place.
- Changes to div_i and burst_i during RUN are ignored; the values are latched in IDLE.
- Requests arriving during RUN wait. There is always at least one IDLE cycle between grants.
- Request dropped mid-burst: behaviour depends on the optional feature.
- Reset asserted mid-burst: everything clears at once, and no done_o pulse is produced.
- Width rules:
  - Divider counter is DIV_W bits and never wraps, because it clears on match.
  - Tick counter is BURST_W bits, so the maximum burst is 2^BURST_W − 1.

Optional Feature:
- Macro PRSC_SCHED_ABORT_EN.
- Defined:
  - Adds output abort_o (1 bit).
  - In RUN, if req_i[k] of the granted requester is 0, the burst aborts that cycle: abort_o = 1 for 1 cycle, no tick_o and no done_o, next state IDLE, pointer unchanged from LOAD.
- Not defined:
  - No abort_o port exists.
  - req_i is sampled only in IDLE, and a started burst always runs to completion.

Decomposition:
- Package prsc_sched_pkg contains:
  - state enum typedef (IDLE, LOAD, RUN)
  - default localparams for DIV_W and BURST_W
  - function eff_div, which maps 0 to 1
- Sub-module rr_arbiter (NUM_REQ parameter):
  - Inputs: req and pointer.
  - Outputs: one-hot grant and encoded index; purely combinational.
  - prsc_sched owns the pointer register.

Test Plan:
- Reset mid-RUN:
  - Requester 2 running (div = 3, burst = 5); assert rstn_i after the 2nd tick.
  - Required: all outputs 0 at once; after release, requester 0 wins first.
- Single requester:
  - req_i = 0001, div = 3, burst = 4.
  - Required: LOAD at cycle 1; ticks at cycles 4, 7, 10, 13; done_o[0] at 13; gnt_o low at 14.
- Round-robin:
  - req_i = 1111 held, each requester with div = 1 and burst = 2.
  - Required: grant order 0, 1, 2, 3, 0.
  - Required: each grant gives 2 consecutive ticks, and each grant is separated from the next by a 1-cycle IDLE.
- Boundaries:
  - div = 0, burst = 0: done_o in LOAD, no tick.
  - div = 0, burst = 3: ticks on 3 consecutive cycles.
  - div = 15, burst = 255: 255 ticks, 15 cycles apart.
- Pause:
  - en_i low for 5 cycles mid-burst (div = 2, burst = 3).
  - Required: no tick during the pause, counters hold, total ticks still 3, and the final tick comes 5 cycles later than it would without the pause.
- Abort (PRSC_SCHED_ABORT_EN defined):
  - Drop req_i[1] after 1 tick of 4.
  - Required: abort_o pulses, no done_o[1], and the next requester is granted after IDLE.
  - Macro undefined: all 4 ticks occur and done_o[1] pulses.
